// File: rtl/id_rom_pkg.sv
// id_rom_pkg: shared state encoding, sentinel and default sizes for the ID ROM search controller
package id_rom_pkg;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ROM_LAT  = 2;
    localparam int DEF_MAX_FAIL = 3;
    localparam int ID_SENTINEL  = 0;
    typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_t;
endpackage

// File: rtl/rom_lat_timer.sv
// rom_lat_timer: loadable down-counter, expired while the count sits at zero
module rom_lat_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/id_rom_search_ctrl.sv
// id_rom_search_ctrl: linear ID ROM lookup with optional consecutive-miss lockout (ID_LOCKOUT_EN)
module id_rom_search_ctrl
    import id_rom_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROM_LAT  = DEF_ROM_LAT,
    parameter int MAX_FAIL = DEF_MAX_FAIL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] id_in,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_idx,
    output logic              locked
);
    localparam int TW = $clog2(ROM_LAT + 1);
    localparam logic [DATA_W-1:0] SENT = DATA_W'(ID_SENTINEL);
    state_t state, nxt;
    logic [DATA_W-1:0] key;
    logic load, expired, hit, last, lock_now;
    // The timer is loaded with ROM_LAT-1 so WAIT lasts exactly ROM_LAT cycles
    rom_lat_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load(load), .value(TW'(ROM_LAT - 1)), .expired(expired)
    );
    assign hit  = q != SENT && q == key;
    assign last = address == {ADDR_W{1'b1}};
    always_comb begin
        nxt  = state;
        load = 1'b0;
        case (state)
            IDLE: if (req) begin
                nxt  = (id_in == SENT || lock_now) ? DONE : WAIT;
                load = 1'b1;
            end
            WAIT: nxt = expired ? CMP : WAIT;
            CMP: begin
                nxt  = (q == SENT || hit || last) ? DONE : WAIT;
                load = nxt == WAIT;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            key       <= '0;
            address   <= '0;
            found     <= 1'b0;
            match_idx <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && req) begin
                key       <= id_in;
                found     <= 1'b0;
                match_idx <= '0;
                if (nxt == WAIT) address <= '0;
            end
            if (state == CMP && hit) begin
                found     <= 1'b1;
                match_idx <= address;
            end else if (state == CMP && nxt == WAIT) begin
                address <= address + 1'b1;
            end
        end
    end
    assign busy = state == WAIT || state == CMP;
    assign done = state == DONE;
`ifdef ID_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [FW-1:0] fail_cnt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            fail_cnt <= '0;
            locked   <= 1'b0;
        end else if (state == CMP && nxt == DONE) begin
            if (hit) fail_cnt <= '0;
            else if (fail_cnt != FW'(MAX_FAIL)) begin
                fail_cnt <= fail_cnt + 1'b1;
                if (fail_cnt == FW'(MAX_FAIL - 1)) locked <= 1'b1;
            end
        end
    end
    assign lock_now = locked;
`else
    assign locked   = 1'b0;
    assign lock_now = 1'b0;
`endif
endmodule

// File: tb/tb_id_rom_search_ctrl.sv
// tb_id_rom_search_ctrl: directed checks of the ID ROM search controller against a 2-cycle ROM model
module tb_id_rom_search_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic        req = 0;
    logic [15:0] id_in = 0;
    logic [15:0] q, p1;
    logic [2:0]  address, match_idx;
    logic        busy, done, found, locked;
    logic [15:0] rom [8];
    int tests = 0;
    int fails = 0;

    id_rom_search_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .id_in(id_in), .q(q), .address(address),
        .busy(busy), .done(done), .found(found), .match_idx(match_idx), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        p1 <= rom[address];
        q  <= p1;
    end

    task automatic load_std();
        rom = '{16'h1234, 16'hBEEF, 16'h0042, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    endtask

    task automatic run(input logic [15:0] id, input int inj, output int dc, output int bc);
        @(negedge clk);
        req = 1; id_in = id;
        dc = -1; bc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) req = 0;
            if (c == inj) begin req = 1; id_in = 16'h1234; end
            if (c == inj + 1) req = 0;
            if (busy) bc++;
            if (done) begin dc = c; break; end
        end
        req = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, found, match_idx, address, locked} !== 10'b0) begin
            fails++;
            $display("FAIL reset: got %b required 0", {busy, done, found, match_idx, address, locked});
        end
        rst = 1;
    endtask

    task automatic test_hit();
        int dc, bc;
        run(16'hBEEF, 0, dc, bc);
        tests++; if (dc !== 7) begin fails++; $display("FAIL hit_done_cycle: got %0d required 7", dc); end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL hit_found: got %b required 1", found); end
        tests++; if (match_idx !== 3'd1) begin fails++; $display("FAIL hit_idx: got %0d required 1", match_idx); end
        tests++; if (bc !== 6) begin fails++; $display("FAIL hit_busy_cycles: got %0d required 6", bc); end
        @(negedge clk);
        tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL hit_pulse: got %b required 00", {done, busy}); end
        tests++; if ({found, match_idx} !== 4'b1001) begin fails++; $display("FAIL hit_hold: got %b required 1001", {found, match_idx}); end
    endtask

    task automatic test_miss();
        int dc, bc;
        run(16'h5555, 0, dc, bc);
        tests++; if (dc !== 13) begin fails++; $display("FAIL miss_done_cycle: got %0d required 13", dc); end
        tests++; if ({found, match_idx} !== 4'b0) begin fails++; $display("FAIL miss_found_idx: got %b required 0", {found, match_idx}); end
        tests++; if (address !== 3'd3) begin fails++; $display("FAIL miss_address: got %0d required 3", address); end
    endtask

    task automatic test_zero_and_ignore();
        int dc, bc;
        run(16'h0000, 0, dc, bc);
        tests++; if (dc !== 1) begin fails++; $display("FAIL zero_done_cycle: got %0d required 1", dc); end
        tests++; if (found !== 1'b0) begin fails++; $display("FAIL zero_found: got %b required 0", found); end
        tests++; if (address !== 3'd3) begin fails++; $display("FAIL zero_address: got %0d required 3", address); end
        @(negedge clk);
        run(16'h0042, 3, dc, bc);
        tests++; if (dc !== 10) begin fails++; $display("FAIL ignore_done_cycle: got %0d required 10", dc); end
        tests++; if ({found, match_idx} !== 4'b1010) begin fails++; $display("FAIL ignore_hit: got %b required 1010", {found, match_idx}); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_not_queued: got busy %b required 0", busy); end
    endtask

    task automatic test_full_table();
        int dc, bc;
        for (int i = 0; i < 8; i++) rom[i] = 16'h1000 + 16'(i);
        run(16'h7777, 0, dc, bc);
        tests++; if (dc !== 25) begin fails++; $display("FAIL full_done_cycle: got %0d required 25", dc); end
        tests++; if ({found, address} !== 4'b0111) begin fails++; $display("FAIL full_found_addr: got %b required 0111", {found, address}); end
        repeat (2) @(negedge clk);
        tests++; if (address !== 3'd7) begin fails++; $display("FAIL full_no_wrap: got %0d required 7", address); end
        load_std();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        @(negedge clk);
        req = 1; id_in = 16'hBEEF;
        @(negedge clk);
        req = 0;
        repeat (4) @(negedge clk);
        rst = 0;
        @(negedge clk);
        tests++;
        if ({busy, done, found, match_idx, address, locked} !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b required 0", {busy, done, found, match_idx, address, locked});
        end
        rst = 1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        tests++; if (seen) begin fails++; $display("FAIL reset_mid_no_done: got done pulse required none"); end
    endtask

`ifdef ID_LOCKOUT_EN
    task automatic test_lockout();
        int dc, bc;
        for (int n = 1; n <= 3; n++) begin
            run(16'h5555, 0, dc, bc);
            tests++;
            if (locked !== (n == 3)) begin fails++; $display("FAIL lock_miss%0d: got %b required %b", n, locked, n == 3); end
        end
        run(16'h1234, 0, dc, bc);
        tests++; if (dc !== 1) begin fails++; $display("FAIL locked_done_cycle: got %0d required 1", dc); end
        tests++; if ({found, address} !== 4'b0011) begin fails++; $display("FAIL locked_found_addr: got %b required 0011", {found, address}); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_cleared: got %b required 0", locked); end
        run(16'h1234, 0, dc, bc);
        tests++; if (dc !== 4) begin fails++; $display("FAIL unlock_done_cycle: got %0d required 4", dc); end
        tests++; if ({found, match_idx} !== 4'b1000) begin fails++; $display("FAIL unlock_hit: got %b required 1000", {found, match_idx}); end
    endtask
`else
    task automatic test_lockout();
        int dc, bc;
        for (int n = 1; n <= 3; n++) run(16'h5555, 0, dc, bc);
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL no_lock: got %b required 0", locked); end
        run(16'h1234, 0, dc, bc);
        tests++; if ({dc, found, match_idx} !== {32'd4, 4'b1000}) begin fails++; $display("FAIL no_lock_hit: got cycle %0d found %b idx %0d required 4 1 0", dc, found, match_idx); end
    endtask
`endif

    initial begin
        load_std();
        test_reset();
        test_hit();
        test_miss();
        test_zero_and_ignore();
        test_full_table();
        test_reset_mid();
        test_lockout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
